// File: rtl/axis_rr_arbiter_if.sv
// axis_rr_arbiter_if: AXI4-Stream bundle of N concatenated lanes plus a stream id.
interface axis_rr_arbiter_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 1
);
    logic [N*DATA_WIDTH-1:0] tdata;
    logic [N*KEEP_WIDTH-1:0] tkeep;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tready;
    logic [N-1:0]            tlast;
    logic [N*USER_WIDTH-1:0] tuser;
    logic [ID_WIDTH-1:0]     tid;
    modport master (output tdata, tkeep, tvalid, tlast, tuser, tid, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, tid, output tready);
endinterface

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin AXI4-Stream arbiter with a skid-buffered output.
module axis_rr_arbiter #(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter bit LAST_ENABLE = 1,
    parameter bit USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_rr_arbiter_if.slave     s_axis,
    axis_rr_arbiter_if.master    m_axis,
    output logic [S_COUNT-1:0]   grant,
    output logic                 busy
);
    localparam int IW = $clog2(S_COUNT);
    localparam int BW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH + IW;
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state;
    logic [IW-1:0] g, last_granted, win, idx;
    logic ready, ready_next, out_valid, temp_valid, in_valid, beat_last;
    logic [BW-1:0] in_beat, out_beat, temp_beat;
    // Scan downward so the lowest offset from last_granted+1 wins.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = S_COUNT - 1; k >= 0; k--) begin
            idx = IW'((int'(last_granted) + 1 + k) % S_COUNT);
            if (s_axis.tvalid[idx]) win = idx;
        end
    end
    assign in_valid = state == ACTIVE && s_axis.tvalid[g] && ready;
    assign beat_last = !LAST_ENABLE || s_axis.tlast[g];
    assign in_beat = {s_axis.tdata[int'(g)*DATA_WIDTH +: DATA_WIDTH], s_axis.tkeep[int'(g)*KEEP_WIDTH +: KEEP_WIDTH],
                      beat_last, s_axis.tuser[int'(g)*USER_WIDTH +: USER_WIDTH], g};
    assign ready_next = m_axis.tready[0] | (!temp_valid & (!out_valid | !in_valid));
    assign s_axis.tready = grant & {S_COUNT{ready}};
    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata = out_beat[BW-1 -: DATA_WIDTH];
    assign m_axis.tkeep = KEEP_ENABLE ? out_beat[BW-DATA_WIDTH-1 -: KEEP_WIDTH] : '1;
    assign m_axis.tlast = out_beat[USER_WIDTH+IW];
    assign m_axis.tuser = USER_ENABLE ? out_beat[IW +: USER_WIDTH] : '0;
    assign m_axis.tid = out_beat[IW-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            busy <= 1'b0;
            g <= '0;
            last_granted <= IW'(S_COUNT - 1);
            ready <= 1'b0;
            out_valid <= 1'b0;
            temp_valid <= 1'b0;
        end else begin
            ready <= ready_next;
            if (state == IDLE) begin
                if (|s_axis.tvalid) begin
                    state <= ACTIVE;
                    busy <= 1'b1;
                    grant <= S_COUNT'(1) << win;
                    g <= win;
                end
            end else if (in_valid && beat_last) begin
                state <= IDLE;
                busy <= 1'b0;
                grant <= '0;
                last_granted <= g;
            end
            if (ready) begin
                if (m_axis.tready[0] || !out_valid) out_valid <= in_valid;
                else temp_valid <= in_valid;
            end else if (m_axis.tready[0]) begin
                out_valid <= temp_valid;
                temp_valid <= 1'b0;
            end
        end
    end
    // Payload registers carry no reset; the valid flags qualify them.
    always_ff @(posedge clk) begin
        if (ready && (m_axis.tready[0] || !out_valid)) out_beat <= in_beat;
        else if (ready) temp_beat <= in_beat;
        else if (m_axis.tready[0]) out_beat <= temp_beat;
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: randomized scoreboard bench with a packet-level round-robin reference model.
module tb_axis_rr_arbiter;
    localparam int S = 4;
    logic clk = 0;
    logic rst = 1;
    logic [S-1:0] grant;
    logic busy;
    axis_rr_arbiter_if #(.N(S), .DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1), .ID_WIDTH(2)) s_if();
    axis_rr_arbiter_if #(.N(1), .DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1), .ID_WIDTH(2)) m_if();
    axis_rr_arbiter #(.S_COUNT(S)) dut (.clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if), .grant(grant), .busy(busy));
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [9:0] q[S][$];
    logic [11:0] exp_q[$];
    logic [S-1:0] cur_v = '0, acc = '0;
    int gap_pct = 0, rdy_pct = 100, rr_last = S - 1;
    bit in_pkt = 0;
    logic [5:0] seq = '0;
    int cyc, first_v, first_g, first_mv, busy_fall, last_acc, prev_acc, acc_cnt, gap2, gapbig, n_out, first_out, last_out;
    logic [S-1:0] first_grant;
    bit was_busy, out_sop;
    int tid_cnt[S];
    int out_ids[$];

    task automatic chk(string name, longint got, longint want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    // Monitor: samples the handshakes that complete on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            acc = '0; cyc = 0; first_v = -1; first_g = -1; first_mv = -1; busy_fall = -1; last_acc = -1;
            prev_acc = -1; acc_cnt = 0; gap2 = 0; gapbig = 0; n_out = 0; first_out = -1; last_out = -1;
            was_busy = 0; out_sop = 1; first_grant = '0; out_ids.delete();
            for (int i = 0; i < S; i++) tid_cnt[i] = 0;
        end else begin
            cyc++;
            acc = s_if.tvalid & s_if.tready;
            chk("ready_onehot0", $onehot0(s_if.tready), 1);
            chk("ready_granted_only", s_if.tready & ~grant, 0);
            chk("skid_occupancy_le2", exp_q.size() <= 2, 1);
            if (|s_if.tvalid && first_v < 0) first_v = cyc;
            if (|grant && first_g < 0) begin first_g = cyc; first_grant = grant; end
            if (busy) was_busy = 1;
            else if (was_busy && busy_fall < 0) busy_fall = cyc;
            if (|acc) begin
                acc_cnt++;
                if (prev_acc >= 0 && cyc - prev_acc == 2) gap2++;
                if (prev_acc >= 0 && cyc - prev_acc > 2) gapbig++;
                prev_acc = cyc;
                if (|(acc & s_if.tlast) && last_acc < 0) last_acc = cyc;
            end
            if (m_if.tvalid[0] && first_mv < 0) first_mv = cyc;
            if (m_if.tvalid[0] && m_if.tready[0]) begin
                if (exp_q.size() == 0) chk("out_unexpected", exp_q.size(), 1);
                else chk("out_beat", {m_if.tdata, m_if.tuser, m_if.tlast, m_if.tid}, exp_q.pop_front());
                chk("out_tkeep", m_if.tkeep, 1);
                n_out++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                tid_cnt[m_if.tid]++;
                if (out_sop) out_ids.push_back(int'(m_if.tid));
                out_sop = m_if.tlast[0];
            end
        end
    end

    // One clock of stimulus: retire accepted beats into the scoreboard, then drive.
    task automatic step();
        int pick;
        @(posedge clk);
        #1;
        for (int s = 0; s < S; s++) begin
            if (acc[s] && q[s].size() > 0) begin
                if (!in_pkt) begin
                    pick = -1;
                    for (int k = S; k >= 1; k--) if (q[(rr_last + k) % S].size() > 0) pick = (rr_last + k) % S;
                    chk("rr_pick", s, pick);
                    rr_last = s;
                end else chk("pkt_hold", s, rr_last);
                in_pkt = !q[s][0][0];
                exp_q.push_back({q[s][0], 2'(s)});
                void'(q[s].pop_front());
                cur_v[s] = 0;
            end
        end
        for (int s = 0; s < S; s++) begin
            if (!cur_v[s] && q[s].size() > 0 && int'($urandom_range(99)) >= gap_pct) cur_v[s] = 1;
            s_if.tvalid[s] = cur_v[s];
            {s_if.tdata[s*8 +: 8], s_if.tuser[s], s_if.tlast[s]} = q[s].size() > 0 ? q[s][0] : 10'h0;
        end
        m_if.tready[0] = int'($urandom_range(99)) < rdy_pct;
    endtask

    task automatic load(int s, int len);
        for (int i = 0; i < len; i++) begin
            q[s].push_back({2'(s), seq, 1'($urandom_range(1)), i == len - 1});
            seq++;
        end
    endtask

    function automatic bit pending();
        int t = exp_q.size();
        for (int s = 0; s < S; s++) t += q[s].size();
        return t != 0;
    endfunction

    task automatic drain(int budget);
        int n = 0;
        while (pending() && n < budget) begin step(); n++; end
        chk("drain_in_time", n < budget, 1);
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst = 1;
        for (int s = 0; s < S; s++) q[s].delete();
        cur_v = '0;
        s_if.tvalid = '0;
        exp_q.delete();
        in_pkt = 0;
        rr_last = S - 1;
        step();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", s_if.tready, 0);
        chk("rst_mvalid", m_if.tvalid, 0);
        step();
        rst = 0;
    endtask

    initial begin
        int n;
        s_if.tvalid = '0; s_if.tdata = '0; s_if.tkeep = '1; s_if.tlast = '0; s_if.tuser = '0; s_if.tid = '0;
        m_if.tready = 1'b1;
        do_reset();
        load(1, 4);
        drain(200);
        chk("t1_grant_delay", first_g - first_v, 1);
        chk("t1_grant", first_grant, 4'b0010);
        chk("t1_mvalid_delay", first_mv - first_v, 2);
        chk("t1_beats", n_out, 4);
        chk("t1_contiguous", last_out - first_out, 3);
        chk("t1_busy_fall", busy_fall - last_acc, 1);
        chk("t1_tid1_beats", tid_cnt[1], 4);
        do_reset();
        load(0, 3); load(0, 3); load(2, 3); load(2, 3);
        drain(300);
        chk("t2_packets", out_ids.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_order", i < out_ids.size() ? out_ids[i] : -1, (i % 2) * 2);
        chk("t2_accepts", acc_cnt, 12);
        chk("t2_one_bubble", gap2, 3);
        chk("t2_no_long_gap", gapbig, 0);
        do_reset();
        for (int p = 0; p < 16; p++) for (int s = 0; s < S; s++) load(s, 1);
        drain(500);
        for (int s = 0; s < S; s++) chk("t3_share", tid_cnt[s], 16);
        chk("t3_total", n_out, 64);
        for (int r = 0; r < S; r++) begin
            do_reset();
            gap_pct = 30;
            rdy_pct = 50;
            load(r, 16);
            drain(1000);
            chk("t4_beats", n_out, 16);
        end
        gap_pct = 0;
        rdy_pct = 100;
        do_reset();
        load(0, 6);
        n = 0;
        while (q[0].size() > 3 && n < 100) begin step(); n++; end
        chk("t5_reach_beat3", q[0].size(), 3);
        do_reset();
        load(1, 2);
        load(3, 2);
        drain(200);
        chk("t5_grant_after_rst", first_grant, 4'b0010);
        chk("t5_beats", n_out, 4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that shares one AXI4-Stream output among S_COUNT input streams. A grant is held from a packet's first beat through the accepted tlast beat, so packets never interleave. The output is driven through an internal skid-buffer stage: full throughput within a packet, and no combinational path from m_axis_tready to any s_axis_tready. It sits between multiple packet producers and a shared downstream consumer, such as a MAC TX path or a DMA write channel.

## Interface
- S_COUNT, 4: number of input streams, 2..16.
- DATA_WIDTH, 8: tdata width per stream.
- KEEP_ENABLE, (DATA_WIDTH>8): propagate tkeep. When 0, m_axis_tkeep = all ones.
- KEEP_WIDTH, (DATA_WIDTH/8): tkeep width.
- LAST_ENABLE, 1: propagate tlast. When 0, every beat is a one-beat packet and m_axis_tlast = 1.
- USER_ENABLE, 1: propagate tuser. When 0, m_axis_tuser = 0.
- USER_WIDTH, 1: tuser width.

Ports (per-stream buses are concatenated; stream i occupies slice i):
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  input data.
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  S_COUNT  per-stream valid.
- s_axis_tready  out  S_COUNT  per-stream ready; one-hot or zero.
- s_axis_tlast  in  S_COUNT  end of packet.
- s_axis_tuser  in  S_COUNT*USER_WIDTH  sideband.
- m_axis_tdata / tkeep / tlast / tuser  out  DATA_WIDTH / KEEP_WIDTH / 1 / USER_WIDTH  output beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tid  out  $clog2(S_COUNT)  index of the source stream of the current output beat.
- grant  out  S_COUNT  registered one-hot grant; 0 when idle.
- busy  out  1  high while a grant is held.

## Operation
- Two states:
  - IDLE: no grant.
  - ACTIVE: grant held by stream g.
- IDLE:
  - Requesters are the streams with s_axis_tvalid = 1.
  - If any exist, the winner is the first requester searching upward from (last_granted+1) mod S_COUNT, wrapping around.
  - The winner is registered into grant and g; state goes to ACTIVE.
  - last_granted resets so that the first search starts at index 0.
- ACTIVE:
  - s_axis_tready[g] = internal output-stage ready register. All other ready bits are 0.
  - A beat transfers on stream g when s_axis_tvalid[g] and s_axis_tready[g] are both high.
  - The beat carries tdata/tkeep/tlast/tuser plus tid = g.
  - A transferred beat with tlast = 1 (or any beat when LAST_ENABLE = 0) clears grant, sets last_granted = g, and returns the state to IDLE on the next edge.
  - If tvalid[g] drops mid-packet, the grant is held and the arbiter waits. There is no timeout.
- Output stage: two-entry skid buffer (output register plus temp register).
  - Internal ready_next = m_axis_tready | (!temp_valid & (!out_valid | !in_valid)).
  - Registered ready gates s_axis_tready[g].
  - Beats leave in order; none is dropped or duplicated.
- Reset:
  - All s_axis_tready = 0, m_axis_tvalid = 0, grant = 0, busy = 0, state IDLE, last_granted = S_COUNT-1.
  - The output and temp registers are invalidated.
  - A packet in flight is abandoned. After reset, the first beat presented is treated as a new packet start.
  - Data registers need no reset; their values are don't-care while invalid.

## Timing
- Arbitration: a request sampled in IDLE at edge t gives grant/busy high after t. s_axis_tready[g] is high in the cycle after t if the output stage is ready.
- Latency: first input beat accepted at edge t+1 gives m_axis_tvalid high after t+1. Worst-case tvalid-to-m_axis_tvalid is 2 cycles.
- Within a packet with m_axis_tready held at 1: one beat per cycle, no bubbles.
- Between packets: the tlast beat accepted at edge k gives IDLE after k, and the next grant after k+1. Exactly one idle input cycle separates packets, including back-to-back packets from the same stream.
- Backpressure: when m_axis_tready falls, at most one further beat is accepted (into the temp register). s_axis_tready[g] falls on the next edge.
- grant, busy, s_axis_tready, and m_axis_tvalid are all register outputs.

## Test plan
- Single stream 1, 4-beat packet, m_axis_tready = 1:
  - grant = 0010 one cycle after tvalid; m_axis_tvalid two cycles after tvalid; m_axis_tid = 1 on all beats.
  - 4 contiguous output beats, tlast on the 4th; busy drops the cycle after the tlast accept.
- Streams 0 and 2 each offer two back-to-back 3-beat packets, S_COUNT = 4:
  - Output order is 0, 2, 0, 2, with no interleave within any packet.
  - Exactly one input bubble between packets.
- All four streams request continuously (1-beat packets, LAST_ENABLE = 0):
  - m_axis_tid sequence is 0, 1, 2, 3, 0, … Each stream gets 25% of grants over 64 packets.
- Random m_axis_tready (50%) and random source tvalid gaps on a 16-beat packet:
  - Output data matches the input sequence exactly; never more than one beat is accepted after m_axis_tready falls; s_axis_tready is never high for a non-granted stream.
- rst asserted at beat 3 of a 6-beat packet:
  - The following cycle shows all readies 0, m_axis_tvalid = 0, grant = 0.
  - After release with streams 1 and 3 requesting, the grant goes to stream 1.
